// File: rtl/instruction_register.sv
`default_nettype none
// ============================================================================
// Module   : instruction_register
// Purpose  : 16-bit instruction register with combinational field decode.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_register #(
  parameter logic [15:0] RESET_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  nsel,
  output logic [15:0] out,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  cond,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [1:0]  shift,
  output logic [4:0]  imm5,
  output logic [7:0]  imm8,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [2:0]  regnum
);

  logic [15:0] ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir <= RESET_VALUE;
    end else if (load) begin
      ir <= in;
    end
  end

  assign out = ir;

  // Every field is sliced from the held word, never from the fetch bus.
  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign cond   = ir[10:8];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];
  assign imm5   = ir[4:0];
  assign imm8   = ir[7:0];
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  // Zero and multi-hot selects resolve to register 0.
  always_comb begin
    regnum = 3'b000;
    case (nsel)
      3'b001:  regnum = ir[2:0];
      3'b010:  regnum = ir[7:5];
      3'b100:  regnum = ir[10:8];
      default: regnum = 3'b000;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_register.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_register
// Purpose  : Directed self-checking bench for instruction_register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_register;

  logic        clk;
  logic        reset_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  nsel;
  logic [15:0] out;
  logic [2:0]  opcode;
  logic [1:0]  op;
  logic [2:0]  cond;
  logic [2:0]  rn;
  logic [2:0]  rd;
  logic [2:0]  rm;
  logic [1:0]  shift;
  logic [4:0]  imm5;
  logic [7:0]  imm8;
  logic [15:0] sximm5;
  logic [15:0] sximm8;
  logic [2:0]  regnum;

  int check_count = 0;
  int pass_count  = 0;

  instruction_register #(.RESET_VALUE(16'h0000)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in      (in),
    .load    (load),
    .nsel    (nsel),
    .out     (out),
    .opcode  (opcode),
    .op      (op),
    .cond    (cond),
    .rn      (rn),
    .rd      (rd),
    .rm      (rm),
    .shift   (shift),
    .imm5    (imm5),
    .imm8    (imm8),
    .sximm5  (sximm5),
    .sximm8  (sximm8),
    .regnum  (regnum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    check_count++;
    if (got === exp) begin
      pass_count++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a word for exactly one rising edge, then drop load.
  task automatic load_word(input logic [15:0] w);
    @(negedge clk);
    in   = w;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    load    = 1'b0;
    in      = 16'h0000;
    nsel    = 3'b000;
    repeat (2) @(negedge clk);
    check("reset_out", out, 16'h0000);
    reset_n = 1'b1;

    // Asynchronous reset mid-cycle clears a full word immediately.
    load_word(16'hFFFF);
    check("preload_ffff", out, 16'hFFFF);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_out", out, 16'h0000);
    check("async_reset_sximm8", sximm8, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    // Load and hold.
    load_word(16'hAAAA);
    check("load_aaaa", out, 16'hAAAA);
    in = 16'h5555;
    repeat (3) @(negedge clk);
    check("hold_aaaa", out, 16'hAAAA);
    load_word(16'h5555);
    check("load_5555", out, 16'h5555);

    // Load held high tracks the input on every edge.
    @(negedge clk);
    in = 16'h1111; load = 1'b1;
    @(negedge clk);
    check("track_1111", out, 16'h1111);
    in = 16'h2222;
    @(negedge clk);
    check("track_2222", out, 16'h2222);
    load = 1'b0;

    // Field decode of 101_10_011_100_01_110.
    load_word(16'hB38E);
    check("dec_opcode", {13'd0, opcode}, 16'h0005);
    check("dec_op",     {14'd0, op},     16'h0002);
    check("dec_cond",   {13'd0, cond},   16'h0003);
    check("dec_rn",     {13'd0, rn},     16'h0003);
    check("dec_rd",     {13'd0, rd},     16'h0004);
    check("dec_shift",  {14'd0, shift},  16'h0001);
    check("dec_rm",     {13'd0, rm},     16'h0006);
    check("dec_imm5",   {11'd0, imm5},   16'h000E);
    check("dec_imm8",   {8'd0, imm8},    16'h008E);
    check("dec_sximm5", sximm5,          16'h000E);
    check("dec_sximm8", sximm8,          16'hFF8E);

    nsel = 3'b001; #1 check("regnum_rm",  {13'd0, regnum}, 16'h0006);
    nsel = 3'b010; #1 check("regnum_rd",  {13'd0, regnum}, 16'h0004);
    nsel = 3'b100; #1 check("regnum_rn",  {13'd0, regnum}, 16'h0003);
    nsel = 3'b011; #1 check("regnum_011", {13'd0, regnum}, 16'h0000);
    nsel = 3'b000; #1 check("regnum_000", {13'd0, regnum}, 16'h0000);
    nsel = 3'b111; #1 check("regnum_111", {13'd0, regnum}, 16'h0000);

    // Reset wins over load across a rising edge; next edge after release captures.
    @(negedge clk);
    in = 16'h1234; load = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    check("rst_priority", out, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_release_load", out, 16'h1234);
    load = 1'b0;

    // Sign-extension boundaries.
    load_word(16'h007F);
    check("sx8_7f", sximm8, 16'h007F);
    load_word(16'h0080);
    check("sx8_80", sximm8, 16'hFF80);
    load_word(16'h0010);
    check("sx5_10", sximm5, 16'hFFF0);
    check("sx8_10", sximm8, 16'h0010);
    load_word(16'h000F);
    check("sx5_0f", sximm5, 16'h000F);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
`default_nettype wire
